// File: rtl/ram_access_arbiter.sv
// Two-requester round-robin arbiter and strobe sequencer for the 16x8 async RAM.
// Each granted access runs IDLE -> STROBE -> HOLD -> ACK, with every output registered.
module ram_access_arbiter #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_bar,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              ack_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              ack_b,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_write_bar,
    output logic              ram_read_bar,
    output logic              ram_output_enable,
    input  logic [DATA_W-1:0] ram_data_out
);

    typedef enum logic [1:0] {StIdle, StStrobe, StHold, StAck} state_t;

    state_t            state_q, state_d;
    logic              grant_b_q, grant_b_d;
    logic              last_b_q, last_b_d;
    logic              op_we_q, op_we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;
    logic              take_a, take_b;

    // A wins a tie only when B had the previous grant.
    assign take_a = req_a && (!req_b || last_b_q);
    assign take_b = req_b && !take_a;

    always_comb begin
        state_d   = state_q;
        grant_b_d = grant_b_q;
        last_b_d  = last_b_q;
        op_we_d   = op_we_q;
        addr_d    = ram_address;
        wdata_d   = ram_data_in;
        unique case (state_q)
            StIdle: begin
                if (take_a || take_b) begin
                    state_d   = StStrobe;
                    grant_b_d = take_b;
                    last_b_d  = take_b;
                    op_we_d   = take_b ? we_b : we_a;
                    addr_d    = take_b ? addr_b : addr_a;
                    wdata_d   = take_b ? wdata_b : wdata_a;
                end
            end
            StStrobe: state_d = StHold;
            StHold:   state_d = StAck;
            StAck:    state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Pins are registered from the current state, so they trail it by one cycle:
    // address/data settle one cycle before the strobe falls and stay after it rises.
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            state_q           <= StIdle;
            grant_b_q         <= 1'b0;
            last_b_q          <= 1'b1;
            op_we_q           <= 1'b0;
            ram_address       <= '0;
            ram_data_in       <= '0;
            ram_write_bar     <= 1'b1;
            ram_read_bar      <= 1'b1;
            ram_output_enable <= 1'b1;
            ack_a             <= 1'b0;
            ack_b             <= 1'b0;
            rdata             <= '0;
            busy              <= 1'b0;
        end else begin
            state_q           <= state_d;
            grant_b_q         <= grant_b_d;
            last_b_q          <= last_b_d;
            op_we_q           <= op_we_d;
            ram_address       <= addr_d;
            ram_data_in       <= wdata_d;
            ram_write_bar     <= !(state_q == StStrobe && op_we_q);
            ram_read_bar      <= !(state_q == StStrobe && !op_we_q);
            ram_output_enable <= !((state_q == StStrobe || state_q == StHold) && !op_we_q);
            ack_a             <= (state_q == StAck) && !grant_b_q;
            ack_b             <= (state_q == StAck) && grant_b_q;
            busy              <= (state_d != StIdle);
            // Output enable is still low during this cycle, so the RAM data is valid.
            if (state_q == StAck && !op_we_q) begin
                rdata <= ram_data_out;
            end
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a behavioural 16x8 RAM on the strobe pins.
module tb_ram_access_arbiter;

    logic       clk = 1'b0;
    logic       reset_bar = 1'b0;
    logic       req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
    logic [3:0] addr_a = '0, addr_b = '0;
    logic [7:0] wdata_a = '0, wdata_b = '0;
    logic       ack_a, ack_b, busy;
    logic [7:0] rdata;
    logic [3:0] ram_address;
    logic [7:0] ram_data_in, ram_data_out;
    logic       ram_write_bar, ram_read_bar, ram_output_enable;

    int checks = 0;
    int failures = 0;

    ram_access_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .reset_bar(reset_bar),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a), .ack_a(ack_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b), .ack_b(ack_b),
        .rdata(rdata), .busy(busy),
        .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_write_bar(ram_write_bar), .ram_read_bar(ram_read_bar),
        .ram_output_enable(ram_output_enable), .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: write while write_bar is low, drive data only while output enabled.
    logic [7:0] mem [16];
    always @(negedge clk) if (!ram_write_bar) mem[ram_address] <= ram_data_in;
    assign ram_data_out = ram_output_enable ? 8'hEE : mem[ram_address];

    // Pin-level mutual exclusion, checked every cycle out of reset.
    always @(negedge clk) begin
        if (reset_bar) begin
            checks++;
            if (!ram_write_bar && !ram_read_bar) begin
                failures++;
                $display("FAIL strobe_excl: write_bar=%b read_bar=%b required not both 0",
                         ram_write_bar, ram_read_bar);
            end
            checks++;
            if (ack_a && ack_b) begin
                failures++;
                $display("FAIL ack_excl: ack_a=%b ack_b=%b required not both 1", ack_a, ack_b);
            end
        end
    end

    int         tr_cyc, tr_wl, tr_rl, tr_ol;
    logic       tr_other, tr_timeout;
    logic [3:0] tr_addr;
    logic [7:0] tr_data;

    task automatic apply_reset();
        reset_bar = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (2) @(negedge clk);
        reset_bar = 1'b1;
        @(negedge clk);
    endtask

    // One transaction for one requester; records pin activity until its ack.
    task automatic txn(input logic sel_b, input logic we, input logic [3:0] a,
                       input logic [7:0] d);
        tr_cyc = 0; tr_wl = 0; tr_rl = 0; tr_ol = 0;
        tr_other = 1'b0; tr_timeout = 1'b0; tr_addr = '0; tr_data = '0;
        if (sel_b) begin
            req_b = 1'b1; we_b = we; addr_b = a; wdata_b = d;
        end else begin
            req_a = 1'b1; we_a = we; addr_a = a; wdata_a = d;
        end
        while (1) begin
            @(negedge clk);
            tr_cyc++;
            if (!ram_write_bar) begin
                tr_wl++; tr_addr = ram_address; tr_data = ram_data_in;
            end
            if (!ram_read_bar) begin
                tr_rl++; tr_addr = ram_address;
            end
            if (!ram_output_enable) tr_ol++;
            if (sel_b ? ack_a : ack_b) tr_other = 1'b1;
            if (sel_b ? ack_b : ack_a) break;
            if (tr_cyc >= 12) begin
                tr_timeout = 1'b1;
                break;
            end
        end
        if (sel_b) req_b = 1'b0;
        else req_a = 1'b0;
    endtask

    task automatic wait_ack(output logic got_a, output logic got_b, output logic to);
        got_a = 1'b0; got_b = 1'b0; to = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack_a || ack_b) begin
                got_a = ack_a; got_b = ack_b; to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_bar = 1'b0;
        #1;
        checks++;
        if ({ram_write_bar, ram_read_bar, ram_output_enable} !== 3'b111) begin
            failures++;
            $display("FAIL reset_strobes: got %b required 111",
                     {ram_write_bar, ram_read_bar, ram_output_enable});
        end
        checks++;
        if ({ack_a, ack_b, busy} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ack_busy: got %b required 000", {ack_a, ack_b, busy});
        end
        checks++;
        if (rdata !== 8'h00 || ram_address !== 4'h0 || ram_data_in !== 8'h00) begin
            failures++;
            $display("FAIL reset_data: rdata=%h addr=%h din=%h required 00 0 00",
                     rdata, ram_address, ram_data_in);
        end
        apply_reset();
    endtask

    task automatic test_write_read();
        txn(1'b0, 1'b1, 4'd5, 8'h3C);
        checks++;
        if (tr_timeout || tr_cyc != 4) begin
            failures++;
            $display("FAIL wr_latency: got %0d cycles (timeout=%b) required 4", tr_cyc, tr_timeout);
        end
        checks++;
        if (tr_wl != 1 || tr_rl != 0 || tr_ol != 0) begin
            failures++;
            $display("FAIL wr_strobes: wl=%0d rl=%0d ol=%0d required 1 0 0", tr_wl, tr_rl, tr_ol);
        end
        checks++;
        if (tr_addr !== 4'd5 || tr_data !== 8'h3C) begin
            failures++;
            $display("FAIL wr_addr_data: got %h/%h required 5/3c", tr_addr, tr_data);
        end
        checks++;
        if (rdata !== 8'h00) begin
            failures++;
            $display("FAIL wr_rdata_kept: got %h required 00", rdata);
        end
        txn(1'b0, 1'b0, 4'd5, 8'h00);
        checks++;
        if (tr_timeout || tr_cyc != 4) begin
            failures++;
            $display("FAIL rd_latency: got %0d cycles (timeout=%b) required 4", tr_cyc, tr_timeout);
        end
        checks++;
        if (rdata !== 8'h3C) begin
            failures++;
            $display("FAIL rd_data: got %h required 3c", rdata);
        end
    endtask

    task automatic test_load_and_read();
        for (int i = 0; i < 16; i++) begin
            txn(1'b1, 1'b1, 4'(i), 8'(i + 16));
            checks++;
            if (tr_timeout || tr_wl != 1 || tr_data !== 8'(i + 16) || tr_addr !== 4'(i)) begin
                failures++;
                $display("FAIL load_%0d: addr=%h data=%h wl=%0d required %h %h 1",
                         i, tr_addr, tr_data, tr_wl, 4'(i), 8'(i + 16));
            end
        end
        for (int i = 0; i < 16; i++) begin
            txn(1'b0, 1'b0, 4'(i), 8'h00);
            checks++;
            if (tr_timeout || rdata !== 8'(i + 16)) begin
                failures++;
                $display("FAIL readback_%0d: got %h required %h", i, rdata, 8'(i + 16));
            end
            checks++;
            if (tr_other) begin
                failures++;
                $display("FAIL readback_ackb_%0d: ack_b seen 1 required 0", i);
            end
        end
    endtask

    task automatic test_contention();
        logic [3:0] order;
        int         n, cyc;
        logic       pend_a, pend_b;
        apply_reset();
        order = '0; n = 0; cyc = 0; pend_a = 1'b0; pend_b = 1'b0;
        we_a = 1'b1; addr_a = 4'd12; wdata_a = 8'hAA;
        we_b = 1'b1; addr_b = 4'd13; wdata_b = 8'hBB;
        req_a = 1'b1; req_b = 1'b1;
        while (n < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (pend_a) begin req_a = 1'b1; pend_a = 1'b0; end
            if (pend_b) begin req_b = 1'b1; pend_b = 1'b0; end
            if (ack_a) begin order[n] = 1'b0; n++; req_a = 1'b0; pend_a = 1'b1; end
            if (ack_b && n < 4) begin order[n] = 1'b1; n++; req_b = 1'b0; pend_b = 1'b1; end
        end
        req_a = 1'b0; req_b = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (n != 4 || order !== 4'b1010) begin
            failures++;
            $display("FAIL rr_order: got %0d grants order=%b required 4 grants 1010 (A,B,A,B)",
                     n, order);
        end
        checks++;
        if (mem[12] !== 8'hAA || mem[13] !== 8'hBB) begin
            failures++;
            $display("FAIL rr_data: got %h/%h required aa/bb", mem[12], mem[13]);
        end
    endtask

    task automatic test_read_phase();
        txn(1'b0, 1'b0, 4'd9, 8'h00);
        checks++;
        if (tr_rl != 1 || tr_ol != 2 || tr_wl != 0) begin
            failures++;
            $display("FAIL rd_phase: rl=%0d ol=%0d wl=%0d required 1 2 0", tr_rl, tr_ol, tr_wl);
        end
        checks++;
        if (tr_addr !== 4'd9 || rdata !== 8'h19) begin
            failures++;
            $display("FAIL rd_phase_data: addr=%h rdata=%h required 9 19", tr_addr, rdata);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        req_b = 1'b1; we_b = 1'b1; addr_b = 4'd7; wdata_b = 8'h5A;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_busy: got %b required 1", busy);
        end
        @(negedge clk);
        checks++;
        if (ram_write_bar !== 1'b0) begin
            failures++;
            $display("FAIL mid_strobe: write_bar=%b required 0", ram_write_bar);
        end
        reset_bar = 1'b0;
        #1;
        checks++;
        if ({ram_write_bar, ram_read_bar, ram_output_enable, busy, ack_b} !== 5'b11100) begin
            failures++;
            $display("FAIL mid_async: wb/rb/oe/busy/ackb=%b required 11100",
                     {ram_write_bar, ram_read_bar, ram_output_enable, busy, ack_b});
        end
        req_b = 1'b0;
        @(negedge clk);
        reset_bar = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ack_b) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL mid_no_ack: ack_b seen 1 required 0");
        end
        txn(1'b0, 1'b0, 4'd0, 8'h00);
        checks++;
        if (tr_timeout || tr_cyc != 4 || rdata !== 8'h10) begin
            failures++;
            $display("FAIL mid_recover: cycles=%0d rdata=%h required 4 10", tr_cyc, rdata);
        end
    endtask

    task automatic test_held_req();
        logic ga, gb, to;
        apply_reset();
        req_a = 1'b1; we_a = 1'b0; addr_a = 4'd3;
        wait_ack(ga, gb, to);
        checks++;
        if (to || !ga || gb) begin
            failures++;
            $display("FAIL held_first: a=%b b=%b timeout=%b required a only", ga, gb, to);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL held_restart: busy=%b required 1", busy);
        end
        req_b = 1'b1; we_b = 1'b0; addr_b = 4'd4;
        wait_ack(ga, gb, to);
        checks++;
        if (to || !ga || gb || rdata !== 8'h13) begin
            failures++;
            $display("FAIL held_second: a=%b b=%b rdata=%h required a only 13", ga, gb, rdata);
        end
        wait_ack(ga, gb, to);
        checks++;
        if (to || ga || !gb || rdata !== 8'h14) begin
            failures++;
            $display("FAIL held_b_first: a=%b b=%b rdata=%h required b only 14", ga, gb, rdata);
        end
        req_b = 1'b0;
        wait_ack(ga, gb, to);
        req_a = 1'b0;
        checks++;
        if (to || !ga || gb) begin
            failures++;
            $display("FAIL held_a_after: a=%b b=%b required a only", ga, gb);
        end
        repeat (6) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_load_and_read();
        test_read_phase();
        test_reset_mid();
        test_contention();
        test_held_req();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
- Two-requester arbiter and access sequencer for the 16x8 async RAM block (active-low write_bar / read_bar / output_enable).
- Requester A is the CPU memory port; requester B is the program-loader port.
- The block grants one requester at a time and drives the RAM strobes with stable address/data setup and hold. It captures read data into a register and returns a one-cycle ack.
- All RAM control pins are driven only by this block.

Parameters:
- ADDR_W, 4, RAM address width (16 locations).
- DATA_W, 8, RAM data width.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset_bar  in  1  asynchronous active-low reset.
- req_a  in  1  requester A transaction request, level.
- we_a  in  1  A: 1 = write, 0 = read; valid while req_a=1.
- addr_a  in  ADDR_W  A address.
- wdata_a  in  DATA_W  A write data.
- ack_a  out  1  one-cycle pulse, A transaction complete.
- req_b, we_b, addr_b, wdata_b, ack_b  same as the A ports, for requester B.
- rdata  out  DATA_W  last read result; valid from the ack cycle until the next read completes.
- busy  out  1  high in any state other than IDLE.
- ram_address  out  ADDR_W  to RAM address.
- ram_data_in  out  DATA_W  to RAM data_in.
- ram_write_bar  out  1  to RAM write_bar, active low.
- ram_read_bar  out  1  to RAM read_bar, active low.
- ram_output_enable  out  1  to RAM output_enable, active low.
- ram_data_out  in  DATA_W  from RAM data_out.

Behaviour:
- Reset (async, reset_bar=0): state=IDLE, ram_address=0, ram_data_in=0, ram_write_bar=1, ram_read_bar=1, ram_output_enable=1, ack_a=ack_b=0, rdata=0, busy=0, last_grant=B (so A wins the first tie).
- Reset mid-transaction: strobes deassert immediately, no ack is issued, and the transaction is dropped.
- All outputs are registered; strobes never glitch.
- FSM states: IDLE, STROBE, HOLD, ACK.
- IDLE:
  - Arbitration: if only one req is high, grant it. If both are high, grant the one that is not last_grant (round-robin).
  - On grant: latch addr/wdata/we of the winner into ram_address/ram_data_in/op register, record the grant, update last_grant, go to STROBE.
  - With no req, stay in IDLE.
- STROBE (1 cycle):
  - Write: ram_write_bar=0.
  - Read: ram_read_bar=0 and ram_output_enable=0.
  - Address and data are stable because they were set one cycle earlier (setup).
- HOLD (1 cycle):
  - ram_write_bar=1 and ram_read_bar=1; address/data unchanged (hold).
  - Read: ram_output_enable stays 0, and rdata <= ram_data_out at the end of HOLD.
- ACK (1 cycle): ram_output_enable=1; ack of the granted requester =1, the other ack =0; next state IDLE.
- Latency: req sampled high at edge N -> ack high in the cycle after edge N+3. Minimum of 4 cycles per transaction.
- Handshake rules:
  - Requester holds req/we/addr/wdata stable until it sees ack.
  - It must drop req on the edge where ack=1, or the next IDLE sample starts a new transaction.
  - Inputs of a non-granted requester are ignored.
- Mutual exclusion: ram_write_bar and ram_read_bar are never both 0; only one ack is high per cycle.
- Write ack: rdata is unchanged.
- A req that rises during STROBE/HOLD/ACK waits until the next IDLE.
- Under continuous contention, A and B alternate.
- Address wrap: none; the full 0..2^ADDR_W-1 range maps directly.

Test Plan:
- Reset, then A writes 0x3C to addr 5 -> write_bar low for exactly 1 cycle with ram_address=5, ram_data_in=0x3C. Then A reads addr 5 -> rdata=0x3C with ack_a in the 4th cycle after req.
- B loads addr 0..15 with data addr+0x10, then A reads all 16 -> each rdata = addr+0x10; ack_b is never high during A's transactions.
- req_a and req_b rise on the same edge right after reset, both writes, and are re-asserted after each ack -> grant order A, B, A, B; acks are never coincident.
- Read phase check -> read_bar low for exactly 1 cycle; output_enable low for 2 cycles (STROBE+HOLD); write_bar stays 1 throughout.
- reset_bar asserted during STROBE of a B write -> all strobes go to 1 asynchronously, no ack_b, busy=0. After release, an A read of 0 succeeds normally.
- req_a held high without dropping after ack -> a second A transaction starts in the following IDLE; with req_b pending, B is served first instead.
